// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential signed radix-2 Booth multiplier.
// A controller steps an A/Q/M/Q-1 register datapath through one EVAL and one
// SHIFT cycle per multiplier bit, then presents a 2*WIDTH-bit product.
// Optional macro BOOTH_OPCNT_EN adds an add/subtract operation counter on
// op_count; without it op_count is tied to zero.
module booth_mul_seq #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 accept;
  logic                 last_shift;

  assign accept     = (state_q == IDLE) && start;
  assign last_shift = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  // Next-state logic: one EVAL/SHIFT pair per multiplier bit, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EVAL;
      EVAL:    state_d = SHIFT;
      SHIFT:   state_d = (cnt_q == LAST_CNT) ? DONE : EVAL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, add/sub on EVAL, arithmetic shift on SHIFT.
  // The product register is written on the final shift so it is already valid while done is high.
  always_comb begin
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d   = {x[WIDTH-1], x};
          q_d   = y;
          a_d   = '0;
          q1_d  = 1'b0;
          cnt_d = '0;
        end
      end
      EVAL: begin
        case ({q_q[0], q1_q})
          2'b01:   a_d = a_q + m_q;
          2'b10:   a_d = a_q - m_q;
          default: a_d = a_q;
        endcase
      end
      SHIFT: begin
        a_d   = {a_q[WIDTH], a_q[WIDTH:1]};
        q_d   = {a_q[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (last_shift) begin
          product_d = {a_d[WIDTH-1:0], q_d};
        end
      end
      default: begin
        a_d = a_q;
      end
    endcase
  end

  // State and datapath registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == EVAL) || (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign product = product_q;

`ifdef BOOTH_OPCNT_EN
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

  // Operation counter: cleared on accept, bumped on every EVAL that adds or subtracts.
  always_comb begin
    op_cnt_d = op_cnt_q;
    if (accept) begin
      op_cnt_d = '0;
    end else if ((state_q == EVAL) && (q_q[0] ^ q1_q)) begin
      op_cnt_d = op_cnt_q + CNT_W'(1);
    end
  end

  // Operation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt_q <= '0;
    end else begin
      op_cnt_q <= op_cnt_d;
    end
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (WIDTH=8): directed corner cases plus
// randomized operands, a scoreboard queue of expected results and a monitor
// that checks every done pulse. Honours BOOTH_OPCNT_EN for op_count.
module tb_booth_mul_seq;

  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic [W-1:0]    x;
  logic [W-1:0]    y;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;
  logic [CW-1:0]   op_count;

  typedef struct {
    logic [2*W-1:0] prod;
    logic [CW-1:0]  ops;
    string          tag;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .op_count (op_count)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference product: plain signed integer multiplication, truncated to 2*W bits.
  function automatic logic [2*W-1:0] modelProduct(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi, p;
    ai = int'($signed(a));
    bi = int'($signed(b));
    p  = ai * bi;
    return p[2*W-1:0];
  endfunction

  // Reference op count: number of bit-value changes scanning y from LSB with an implicit 0 below it.
  function automatic logic [CW-1:0] modelOps(input logic [W-1:0] b);
    int   n;
    logic prev;
    n    = 0;
    prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (b[i] != prev) n++;
      prev = b[i];
    end
`ifdef BOOTH_OPCNT_EN
    return CW'(n);
`else
    return CW'(0);
`endif
  endfunction

  // Queue the expected result of an accepted operation.
  task automatic pushExp(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    exp_t e;
    e.prod = modelProduct(a, b);
    e.ops  = modelOps(b);
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput({"product_", e.tag}, 32'(product), 32'(e.prod));
        checkOutput({"op_count_", e.tag}, 32'(op_count), 32'(e.ops));
      end
    end
  end

  // Wait (bounded) at a falling edge until the DUT is idle.
  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one operation, optionally pulse a stray start at busy cycle ignoreAt, and check timing.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int ignoreAt, input string tag);
    int cycles, busyCnt;
    waitIdle();
    start = 1'b1;
    x     = a;
    y     = b;
    @(posedge clk);
    pushExp(a, b, tag);
    #1;
    start = 1'b0;
    x     = W'($urandom);
    y     = W'($urandom);
    cycles  = 0;
    busyCnt = 0;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (busy) busyCnt++;
      if (ignoreAt != 0 && cycles == ignoreAt) begin
        start = 1'b1;
        x     = 8'd9;
        y     = 8'd9;
      end else if (ignoreAt != 0 && cycles == ignoreAt + 1) begin
        start = 1'b0;
      end
      if (done) break;
    end
    checkOutput({"done_cycle_", tag}, 32'(cycles), 32'd17);
    checkOutput({"busy_len_", tag}, 32'(busyCnt), 32'd16);
  endtask

  // Hold start high across done: the second operation must begin right after the done cycle.
  task automatic runHeld(input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic [W-1:0] a2, input logic [W-1:0] b2);
    int cycles;
    waitIdle();
    start = 1'b1;
    x     = a1;
    y     = b1;
    @(posedge clk);
    pushExp(a1, b1, "held1");
    cycles = 0;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    checkOutput("held1_done_cycle", 32'(cycles), 32'd17);
    x = a2;
    y = b2;
    @(posedge clk);
    @(posedge clk);
    pushExp(a2, b2, "held2");
    #1;
    start = 1'b0;
    cycles = 0;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    checkOutput("held2_done_cycle", 32'(cycles), 32'd17);
  endtask

  // Start an operation and assert reset between edges in its sixth cycle.
  task automatic abortWithReset(input logic [W-1:0] a, input logic [W-1:0] b);
    waitIdle();
    start = 1'b1;
    x     = a;
    y     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_product", 32'(product), 32'd0);
    checkOutput("abort_op_count", 32'(op_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_product", 32'(product), 32'd0);
    checkOutput("reset_op_count", 32'(op_count), 32'd0);
    rst = 1'b0;

    applyStimulus(8'd3, 8'd5, 0, "3x5");
    checkOutput("direct_3x5", 32'(modelProduct(8'd3, 8'd5)), 32'h000F);
    applyStimulus(8'hF9, 8'd6, 0, "m7x6");
    applyStimulus(8'h80, 8'h80, 0, "m128xm128");
    applyStimulus(8'h7F, 8'h80, 0, "127xm128");
    applyStimulus(8'd3, 8'd5, 4, "ignore");
    runHeld(8'd11, 8'hF3, 8'h80, 8'h7F);

    abortWithReset(8'd3, 8'd5);
    applyStimulus(8'd2, 8'hFD, 0, "2xm3");

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 8'h80;
        1:       ra = 8'h7F;
        default: ra = W'($urandom);
      endcase
      rb = W'($urandom);
      applyStimulus(ra, rb, 0, "rand");
    end

    repeat (25) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
